// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and defaults for the CPU run controller.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRun,
    StDone
  } run_state_e;

  localparam int unsigned DefNumCores   = 1;
  localparam int unsigned DefHoldCycles = 2;
  localparam int unsigned DefStagger    = 0;
  localparam int unsigned DefRunCycles  = 100;
  localparam int unsigned DefCntW       = 32;
  localparam int unsigned MaxCntW       = 64;

  // A zero budget selects the build-time default.
  function automatic logic [MaxCntW-1:0] sel_limit(input logic [MaxCntW-1:0] cfg,
                                                   input logic [MaxCntW-1:0] dflt);
    return (cfg == '0) ? dflt : cfg;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_release.sv
// Hold counter and per-core release comparators for staggered reset release.
module cpu_run_ctrl_release #(
  parameter int unsigned NUM_CORES   = 1,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned STAGGER     = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 advance,
  output logic [NUM_CORES-1:0] release_next,
  output logic                 last
);

  localparam int unsigned LastThresh = HOLD_CYCLES + (NUM_CORES - 1) * STAGGER;
  localparam int unsigned HoldW      = $clog2(LastThresh + 1);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [HoldW:0]   cnt_inc;

  // Comparisons use the count the counter reaches on this edge.
  assign cnt_inc = {1'b0, hold_cnt_q} + (HoldW + 1)'(1);
  assign last    = advance && (cnt_inc == (HoldW + 1)'(LastThresh));

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_rel
    assign release_next[i] = advance && (cnt_inc >= (HoldW + 1)'(HOLD_CYCLES + i * STAGGER));
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (clear) begin
      hold_cnt_d = '0;
    end else if (advance) begin
      hold_cnt_d = cnt_inc[HoldW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: staggered core reset release, cycle budget, halt/timeout detection.
// Optional retire counting is built when CPU_RUN_CTRL_PERF_EN is defined.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES   = DefNumCores,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles,
  parameter int unsigned STAGGER     = DefStagger,
  parameter int unsigned RUN_CYCLES  = DefRunCycles,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     cfg_run_cycles,
  input  logic [NUM_CORES-1:0] halt_req,
`ifdef CPU_RUN_CTRL_PERF_EN
  input  logic [NUM_CORES-1:0] retire_valid,
  output logic [CNT_W-1:0]     retire_count,
`endif
  output logic [NUM_CORES-1:0] core_reset_n,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count
);

  run_state_e           state_q, state_d;
  logic [NUM_CORES-1:0] core_reset_n_q, core_reset_n_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]     limit_q, limit_d;
  logic                 start_acc;
  logic [NUM_CORES-1:0] rel_next;
  logic                 rel_last;

  assign start_acc = start && !abort && ((state_q == StIdle) || (state_q == StDone));
  assign cnt_inc   = cnt_q + CNT_W'(1);

  cpu_run_ctrl_release #(
    .NUM_CORES  (NUM_CORES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .STAGGER    (STAGGER)
  ) u_release (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (start_acc),
    .advance     (state_q == StHold),
    .release_next(rel_next),
    .last        (rel_last)
  );

  always_comb begin
    state_d        = state_q;
    core_reset_n_d = core_reset_n_q;
    done_d         = done_q;
    timeout_d      = timeout_q;
    cnt_d          = cnt_q;
    limit_d        = limit_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_acc) begin
          state_d        = StHold;
          core_reset_n_d = '0;
          done_d         = 1'b0;
          timeout_d      = 1'b0;
          cnt_d          = '0;
          limit_d        = CNT_W'(sel_limit(MaxCntW'(cfg_run_cycles), MaxCntW'(RUN_CYCLES)));
        end
      end
      StHold: begin
        core_reset_n_d = core_reset_n_q | rel_next;
        if (rel_last) begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        // Halt is checked first so it wins over a coincident budget hit.
        if (&halt_req) begin
          state_d        = StDone;
          core_reset_n_d = '0;
          done_d         = 1'b1;
          timeout_d      = 1'b0;
        end else if (cnt_inc == limit_q) begin
          state_d        = StDone;
          core_reset_n_d = '0;
          done_d         = 1'b1;
          timeout_d      = 1'b1;
        end
      end
      default: begin
        state_d        = StIdle;
        core_reset_n_d = '0;
      end
    endcase

    if (abort) begin
      state_d        = StIdle;
      core_reset_n_d = '0;
      done_d         = 1'b0;
      timeout_d      = 1'b0;
      cnt_d          = cnt_q;
      limit_d        = limit_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      core_reset_n_q <= '0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      cnt_q          <= '0;
      limit_q        <= CNT_W'(RUN_CYCLES);
    end else begin
      state_q        <= state_d;
      core_reset_n_q <= core_reset_n_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      cnt_q          <= cnt_d;
      limit_q        <= limit_d;
    end
  end

  assign core_reset_n = core_reset_n_q;
  assign running      = (state_q == StRun);
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cnt_q;

`ifdef CPU_RUN_CTRL_PERF_EN
  localparam int unsigned PopW = $clog2(NUM_CORES + 1);

  logic [CNT_W-1:0] retire_q, retire_d;
  logic [PopW-1:0]  pop;
  logic [CNT_W:0]   retire_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      pop = pop + PopW'(retire_valid[i]);
    end
  end

  // Extra top bit catches overflow so the count saturates instead of wrapping.
  assign retire_sum = {1'b0, retire_q} + (CNT_W + 1)'(pop);

  always_comb begin
    retire_d = retire_q;
    if (start_acc) begin
      retire_d = '0;
    end else if (state_q == StRun) begin
      retire_d = retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;
`else
  // Retire counting not built; no extra ports or state.
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: one default instance and one 3-core staggered instance.
module tb_cpu_run_ctrl;

  localparam int unsigned CntW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst1_n, start1, abort1;
  logic [CntW-1:0] cfg1;
  logic [0:0]      halt1, crn1;
  logic            running1, done1, timeout1;
  logic [CntW-1:0] cnt1;

  logic            rst3_n, start3, abort3;
  logic [CntW-1:0] cfg3;
  logic [2:0]      halt3, crn3;
  logic            running3, done3, timeout3;
  logic [CntW-1:0] cnt3;

`ifdef CPU_RUN_CTRL_PERF_EN
  logic [0:0]      rv1;
  logic [CntW-1:0] rc1;
  logic [2:0]      rv3;
  logic [CntW-1:0] rc3;
`endif

  cpu_run_ctrl dut1 (
    .clk           (clk),
    .reset_n       (rst1_n),
    .start         (start1),
    .abort         (abort1),
    .cfg_run_cycles(cfg1),
    .halt_req      (halt1),
`ifdef CPU_RUN_CTRL_PERF_EN
    .retire_valid  (rv1),
    .retire_count  (rc1),
`endif
    .core_reset_n  (crn1),
    .running       (running1),
    .done          (done1),
    .timeout       (timeout1),
    .cycle_count   (cnt1)
  );

  cpu_run_ctrl #(
    .NUM_CORES  (3),
    .HOLD_CYCLES(2),
    .STAGGER    (2),
    .RUN_CYCLES (100),
    .CNT_W      (CntW)
  ) dut3 (
    .clk           (clk),
    .reset_n       (rst3_n),
    .start         (start3),
    .abort         (abort3),
    .cfg_run_cycles(cfg3),
    .halt_req      (halt3),
`ifdef CPU_RUN_CTRL_PERF_EN
    .retire_valid  (rv3),
    .retire_count  (rc3),
`endif
    .core_reset_n  (crn3),
    .running       (running3),
    .done          (done3),
    .timeout       (timeout3),
    .cycle_count   (cnt3)
  );

  typedef struct packed {
    logic            done;
    logic            timeout;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   run1   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (running1) run1++;
  endtask

  task automatic wait_done1(input int bound, input string tag);
    exp_t e;
    for (int i = 0; i < bound && !done1; i++) tick();
    e = exp_q.pop_front();
    check({tag, "_done"}, 64'(done1), 64'(e.done));
    check({tag, "_timeout"}, 64'(timeout1), 64'(e.timeout));
    check({tag, "_count"}, 64'(cnt1), 64'(e.cnt));
    check({tag, "_crn"}, 64'(crn1), 64'(0));
    check({tag, "_running"}, 64'(running1), 64'(0));
  endtask

  task automatic wait_done3(input int bound, input string tag);
    exp_t e;
    for (int i = 0; i < bound && !done3; i++) tick();
    e = exp_q.pop_front();
    check({tag, "_done"}, 64'(done3), 64'(e.done));
    check({tag, "_timeout"}, 64'(timeout3), 64'(e.timeout));
    check({tag, "_count"}, 64'(cnt3), 64'(e.cnt));
    check({tag, "_crn"}, 64'(crn3), 64'(0));
    check({tag, "_running"}, 64'(running3), 64'(0));
  endtask

  logic [2:0] rel_exp [6];

  initial begin
    rst1_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; cfg1 = '0; halt1 = '0;
    rst3_n = 1'b0; start3 = 1'b0; abort3 = 1'b0; cfg3 = '0; halt3 = '0;
`ifdef CPU_RUN_CTRL_PERF_EN
    rv1 = '0; rv3 = '0;
`endif
    rel_exp = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};

    #12;
    check("rst_crn1", 64'(crn1), 64'(0));
    check("rst_running1", 64'(running1), 64'(0));
    check("rst_done1", 64'(done1), 64'(0));
    check("rst_timeout1", 64'(timeout1), 64'(0));
    check("rst_cnt1", 64'(cnt1), 64'(0));
    check("rst_crn3", 64'(crn3), 64'(0));
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    tick();
    tick();

    // Default budget, release timing, start ignored while running.
    cfg1 = '0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    run1 = 0;
    check("t1_hold0_crn", 64'(crn1), 64'(0));
    check("t1_hold0_running", 64'(running1), 64'(0));
    tick();
    check("t1_hold1_crn", 64'(crn1), 64'(0));
    tick();
    check("t1_rel_crn", 64'(crn1), 64'(1));
    check("t1_rel_running", 64'(running1), 64'(1));
    check("t1_rel_cnt", 64'(cnt1), 64'(0));
    exp_q.push_back('{done: 1'b1, timeout: 1'b1, cnt: CntW'(100)});
    for (int i = 0; i < 200 && cnt1 != 50; i++) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("t1_start_ignored_cnt", 64'(cnt1), 64'(51));
    check("t1_start_ignored_running", 64'(running1), 64'(1));
    wait_done1(200, "t1");
    check("t1_run_len", 64'(run1), 64'(100));

    // Restart from DONE, halt before budget.
    cfg1 = CntW'(10);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("t2_cleared_cnt", 64'(cnt1), 64'(0));
    check("t2_cleared_done", 64'(done1), 64'(0));
    check("t2_cleared_timeout", 64'(timeout1), 64'(0));
    tick();
    tick();
    check("t2_running", 64'(running1), 64'(1));
    exp_q.push_back('{done: 1'b1, timeout: 1'b0, cnt: CntW'(4)});
    repeat (3) tick();
    check("t2_cnt3", 64'(cnt1), 64'(3));
    halt1 = 1'b1;
    wait_done1(20, "t2");
    halt1 = 1'b0;

    // Halt coinciding with budget exhaustion.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    exp_q.push_back('{done: 1'b1, timeout: 1'b0, cnt: CntW'(10)});
    repeat (9) tick();
    halt1 = 1'b1;
    wait_done1(20, "t3");
    halt1 = 1'b0;

    // Abort during RUN keeps the count.
    cfg1 = CntW'(20);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    repeat (7) tick();
    check("t4_cnt7", 64'(cnt1), 64'(7));
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("t4_done", 64'(done1), 64'(0));
    check("t4_running", 64'(running1), 64'(0));
    check("t4_crn", 64'(crn1), 64'(0));
    check("t4_cnt", 64'(cnt1), 64'(7));

    // Abort wins over a simultaneous start.
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    check("t5_cnt_kept", 64'(cnt1), 64'(7));
    tick();
    tick();
    check("t5_crn", 64'(crn1), 64'(0));
    check("t5_running", 64'(running1), 64'(0));

    // Asynchronous reset mid-RUN.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    repeat (5) tick();
    check("t6_cnt5", 64'(cnt1), 64'(5));
    #2 rst1_n = 1'b0;
    #1;
    check("t6_async_cnt", 64'(cnt1), 64'(0));
    check("t6_async_crn", 64'(crn1), 64'(0));
    check("t6_async_running", 64'(running1), 64'(0));
    #2 rst1_n = 1'b1;

    // Three cores, stagger 2: releases at +2/+4/+6, partial halt ignored.
    cfg3 = '0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("t7_rel%0d", j + 1), 64'(crn3), 64'(rel_exp[j]));
    end
    check("t7_running", 64'(running3), 64'(1));
    check("t7_cnt0", 64'(cnt3), 64'(0));
    halt3 = 3'b011;
`ifdef CPU_RUN_CTRL_PERF_EN
    rv3 = 3'b011;
`endif
    repeat (5) tick();
`ifdef CPU_RUN_CTRL_PERF_EN
    rv3 = 3'b000;
    check("t7_retire", 64'(rc3), 64'(10));
`endif
    check("t7_partial_halt_done", 64'(done3), 64'(0));
    check("t7_cnt5", 64'(cnt3), 64'(5));
    exp_q.push_back('{done: 1'b1, timeout: 1'b0, cnt: CntW'(6)});
    halt3 = 3'b111;
    wait_done3(20, "t7");
    halt3 = 3'b000;
`ifdef CPU_RUN_CTRL_PERF_EN
    tick();
    check("t7_retire_frozen", 64'(rc3), 64'(10));
`endif

    // Asynchronous reset mid-HOLD.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    tick();
    check("t8_hold_crn", 64'(crn3), 64'(3'b001));
    #2 rst3_n = 1'b0;
    #1;
    check("t8_async_crn", 64'(crn3), 64'(0));
    check("t8_async_running", 64'(running3), 64'(0));
    check("t8_async_done", 64'(done3), 64'(0));
    #2 rst3_n = 1'b1;
    repeat (5) tick();
    check("t8_stays_idle", 64'(crn3), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
